shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
Sequencer for the 4-bit universal shift register family (conditional, structural, yosys and delay variants), which all share one control interface. It accepts parallel words over a valid/ready handshake and drives the register's ENB/MODO/DIR/D/S_IN controls. Each word is loaded, then shifted out serially. The register's S_OUT is returned as a qualified bit stream with end-of-frame and frame-count reporting. It sits between the stimulus/host logic and the register under test, and is shared by every register variant in the bench.

Parameters:
WIDTH, 4, register width and number of shift cycles per frame.
FRAME_GAP, 1, idle cycles after the last shift before the next command is accepted (must be >= 1).
FILL_BIT, 0, value driven on SR_S_IN during shifts.

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET_L  in  1  reset, asynchronous and active-low.
CMD_VALID  in  1  command word present.
CMD_READY  out  1  controller can accept a command; equals (state==IDLE).
CMD_DATA  in  WIDTH  word to serialize.
CMD_DIR  in  1  1 = MSB-first (shift left), 0 = LSB-first (shift right).
ABORT  in  1  synchronous frame cancel.
SR_ENB  out  1  register enable.
SR_MODO  out  2  register mode (HOLD/SHIFT/LOAD).
SR_DIR  out  1  register shift direction.
SR_D  out  WIDTH  register parallel-load data.
SR_S_IN  out  1  register serial input.
SR_S_OUT  in  1  register serial output; holds the bit shifted out on the previous enabled shift edge.
BIT_VALID  out  1  BIT_OUT is a frame bit this cycle.
BIT_OUT  out  1  serial data, equals SR_S_OUT when BIT_VALID=1, else 0.
DONE  out  1  one-cycle pulse coincident with the last BIT_VALID of a completed frame.
FRAME_CNT  out  8  completed frames, saturates at 255.

Behaviour:
- Handshake: a command is accepted on the posedge where CMD_VALID=1 and CMD_READY=1. That edge latches CMD_DATA and CMD_DIR.
- CMD_VALID while busy is ignored. CMD_DATA and CMD_DIR changes after acceptance have no effect.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE: SR_ENB=0, SR_MODO=HOLD. The accepting edge moves to LOAD.
- LOAD: 1 cycle. SR_ENB=1, SR_MODO=LOAD, SR_D=latched data. Moves to SHIFT and clears the bit counter.
- SHIFT: WIDTH cycles. SR_ENB=1, SR_MODO=SHIFT, SR_DIR=latched dir, SR_S_IN=FILL_BIT. The counter increments each cycle. At count WIDTH-1 the FSM moves to GAP.
- GAP: FRAME_GAP cycles. SR_ENB=0, SR_MODO=HOLD. Then returns to IDLE.
- Timing, with cycle 1 the cycle after the accepting edge:
  - LOAD occupies cycle 1.
  - SHIFT occupies cycles 2..WIDTH+1.
  - GAP occupies cycles WIDTH+2..WIDTH+1+FRAME_GAP.
  - CMD_READY is high again at cycle WIDTH+2+FRAME_GAP.
- BIT_VALID is registered as (state==SHIFT), so it is high in cycles 3..WIDTH+2. DONE is high in cycle WIDTH+2 only. FRAME_CNT increments on the edge ending the DONE cycle.
- SR_D holds the latched word in all states. It is not cleared in IDLE.
- ABORT is sampled at each posedge.
  - In LOAD or SHIFT it forces GAP (full FRAME_GAP). The pending BIT_VALID is suppressed from the next cycle.
  - An aborted frame produces no DONE and no FRAME_CNT increment.
  - ABORT is ignored in IDLE and GAP.
  - ABORT and an accepting edge in the same cycle: the command is accepted.
- FRAME_CNT at 255 stays at 255.
- Reset (RESET_L=0, at any time including mid-frame):
  - state=IDLE, counters=0, latched data=0, latched dir=0.
  - Outputs: SR_ENB=0, SR_MODO=HOLD, SR_DIR=0, SR_D=0, SR_S_IN=FILL_BIT, BIT_VALID=0, BIT_OUT=0, DONE=0, FRAME_CNT=0.
  - CMD_READY=1 (IDLE), but CMD_VALID is not accepted while RESET_L=0.
  - The first acceptance is possible on the first posedge after release.

Decomposition:
- definitions.v (shared include) holds:
  - MODO encodings `MODE_HOLD=2'b00, `MODE_SHIFT=2'b01, `MODE_LOAD=2'b10.
  - DIR encodings `DIR_LEFT=1, `DIR_RIGHT=0.
  - FSM state encodings.
- One sub-module: shift_ctrl_counter, a loadable down-counter reused for the SHIFT bit count and the GAP count. Everything else stays in shift_reg_ctrl.

Test Plan:
- Reset: RESET_L=0 asserted in cycle 3 of a frame -> all outputs take their reset values immediately. CMD_READY=1 after release. FRAME_CNT=0.
- MSB-first: CMD_DATA=4'b1011, CMD_DIR=1, FRAME_GAP=1 -> SR_MODO=LOAD in c1 and SHIFT in c2-c5; BIT_OUT 1,0,1,1 in c3-c6; DONE in c6; CMD_READY in c7; FRAME_CNT=1.
- LSB-first: CMD_DATA=4'b1011, CMD_DIR=0 -> BIT_OUT 1,1,0,1 in c3-c6; SR_DIR=0 throughout SHIFT.
- Back-to-back: CMD_VALID held with 4'hA then 4'h5 -> second accept at the c7 edge, no overlap of BIT_VALID windows, FRAME_CNT=2. CMD_DATA changes during frame 1 do not alter its bits.
- Abort: ABORT=1 at the c3 edge -> BIT_VALID low from c4, no DONE, GAP for 1 cycle, CMD_READY at c5, FRAME_CNT unchanged.
- Saturation: 256 frames -> FRAME_CNT=255 and it stays 255 after a 257th frame.

Source files
------------

// File: rtl/shift_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_ctrl_pkg
// Description : Shared encodings for the universal shift register sequencer:
//               register mode codes, shift direction codes and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_ctrl_pkg;

  // Register mode codes driven on SR_MODO
  localparam logic [1:0] c_mode_hold  = 2'b00;
  localparam logic [1:0] c_mode_shift = 2'b01;
  localparam logic [1:0] c_mode_load  = 2'b10;

  // Register shift direction codes driven on SR_DIR
  localparam logic c_dir_left  = 1'b1;
  localparam logic c_dir_right = 1'b0;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

endpackage : shift_reg_ctrl_pkg
`default_nettype wire

// File: rtl/shift_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl_counter
// Description : Loadable down-counter that stops at zero. Times both the
//               SHIFT bit count and the GAP idle count of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ctrl_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load takes priority, otherwise decrement and hold at zero
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule : shift_ctrl_counter
`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_ctrl
// Description : Sequencer for the 4-bit universal shift register family.
//               Accepts words over valid/ready, loads them into the register,
//               shifts them out serially and qualifies the returned S_OUT
//               stream with BIT_VALID, DONE and a saturating frame count.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_ctrl #(
  parameter int   WIDTH     = 4,
  parameter int   FRAME_GAP = 1,
  parameter logic FILL_BIT  = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CMD_DIR,
  input  logic             ABORT,
  output logic             SR_ENB,
  output logic [1:0]       SR_MODO,
  output logic             SR_DIR,
  output logic [WIDTH-1:0] SR_D,
  output logic             SR_S_IN,
  input  logic             SR_S_OUT,
  output logic             BIT_VALID,
  output logic             BIT_OUT,
  output logic             DONE,
  output logic [7:0]       FRAME_CNT
);

  import shift_reg_ctrl_pkg::*;

  // One counter serves both phases, so size it for the longer of the two
  localparam int CNT_MAX = (WIDTH > FRAME_GAP) ? WIDTH : FRAME_GAP;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] c_shift_load = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_gap_load   = CNT_W'(FRAME_GAP - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               dir_q, dir_d;
  logic               bit_valid_q, bit_valid_d;
  logic               done_q, done_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               sr_enb_q, sr_enb_d;
  logic [1:0]         sr_modo_q, sr_modo_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;

  shift_ctrl_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (CLK),
    .rst_n      (RESET_L),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  // Next-state, counter control and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    dir_d        = dir_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    bit_valid_d  = 1'b0;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // The count advances on the edge that ends the DONE cycle
    if (done_q && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        // ABORT has no meaning here; an offered command is always taken
        if (CMD_VALID) begin
          state_d = S_LOAD;
          data_d  = CMD_DATA;
          dir_d   = CMD_DIR ? c_dir_left : c_dir_right;
        end
      end
      S_LOAD: begin
        cnt_load = 1'b1;
        if (ABORT) begin
          state_d      = S_GAP;
          cnt_load_val = c_gap_load;
        end else begin
          state_d      = S_SHIFT;
          cnt_load_val = c_shift_load;
        end
      end
      S_SHIFT: begin
        // The bit shifted out this cycle appears on S_OUT next cycle
        bit_valid_d = !ABORT;
        if (ABORT || cnt_zero) begin
          state_d      = S_GAP;
          cnt_load     = 1'b1;
          cnt_load_val = c_gap_load;
          done_d       = !ABORT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Register controls follow the state being entered so they line up with it
    sr_enb_d  = (state_d == S_LOAD) || (state_d == S_SHIFT);
    sr_modo_d = (state_d == S_LOAD)  ? c_mode_load  :
                (state_d == S_SHIFT) ? c_mode_shift : c_mode_hold;
  end

  // Sequencer state and registered outputs
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      dir_q       <= c_dir_right;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      sr_enb_q    <= 1'b0;
      sr_modo_q   <= c_mode_hold;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      sr_enb_q    <= sr_enb_d;
      sr_modo_q   <= sr_modo_d;
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign SR_ENB    = sr_enb_q;
  assign SR_MODO   = sr_modo_q;
  assign SR_DIR    = dir_q;
  assign SR_D      = data_q;
  assign SR_S_IN   = FILL_BIT;
  assign BIT_VALID = bit_valid_q;
  assign BIT_OUT   = bit_valid_q & SR_S_OUT;
  assign DONE      = done_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule : shift_reg_ctrl
`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_ctrl
// Description : Bench for shift_reg_ctrl. Contains a 4-bit universal shift
//               register model driven by the sequencer, a frame-timeline
//               reference model checked every cycle, and directed vectors
//               with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_ctrl;

  localparam int W = 4;
  localparam int G = 1;

  logic         CLK = 1'b0;
  logic         RESET_L;
  logic         CMD_VALID;
  logic         CMD_READY;
  logic [W-1:0] CMD_DATA;
  logic         CMD_DIR;
  logic         ABORT;
  logic         SR_ENB;
  logic [1:0]   SR_MODO;
  logic         SR_DIR;
  logic [W-1:0] SR_D;
  logic         SR_S_IN;
  logic         SR_S_OUT;
  logic         BIT_VALID;
  logic         BIT_OUT;
  logic         DONE;
  logic [7:0]   FRAME_CNT;

  int total = 0;
  int bad   = 0;

  shift_reg_ctrl #(
    .WIDTH     (W),
    .FRAME_GAP (G),
    .FILL_BIT  (1'b0)
  ) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_DATA  (CMD_DATA),
    .CMD_DIR   (CMD_DIR),
    .ABORT     (ABORT),
    .SR_ENB    (SR_ENB),
    .SR_MODO   (SR_MODO),
    .SR_DIR    (SR_DIR),
    .SR_D      (SR_D),
    .SR_S_IN   (SR_S_IN),
    .SR_S_OUT  (SR_S_OUT),
    .BIT_VALID (BIT_VALID),
    .BIT_OUT   (BIT_OUT),
    .DONE      (DONE),
    .FRAME_CNT (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register under test: universal 4-bit shift register driven by the sequencer
  logic [W-1:0] sr_reg = '0;
  logic         s_out  = 1'b0;
  assign SR_S_OUT = s_out;

  always @(posedge CLK) begin
    if (SR_ENB) begin
      if (SR_MODO == 2'b10) begin
        sr_reg <= SR_D;
      end else if (SR_MODO == 2'b01) begin
        if (SR_DIR) begin
          s_out  <= sr_reg[W-1];
          sr_reg <= {sr_reg[W-2:0], SR_S_IN};
        end else begin
          s_out  <= sr_reg[0];
          sr_reg <= {SR_S_IN, sr_reg[W-1:1]};
        end
      end
    end
  end

  // Reference model: phase p counts cycles since the accepting edge (p=1 is LOAD)
  bit           m_busy = 1'b0;
  int           m_p    = 0;
  logic [W-1:0] m_word = '0;
  logic         m_dir  = 1'b0;
  bit           m_ab   = 1'b0;
  int           m_pa   = 0;
  int           m_fcnt = 0;

  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      m_busy = 1'b0; m_p = 0; m_word = '0; m_dir = 1'b0;
      m_ab = 1'b0; m_pa = 0; m_fcnt = 0;
    end else if (!m_busy) begin
      if (CMD_VALID) begin
        m_busy = 1'b1; m_p = 1; m_word = CMD_DATA; m_dir = CMD_DIR; m_ab = 1'b0;
      end
    end else begin
      if (!m_ab && (m_p <= W + 1) && ABORT) begin
        m_ab = 1'b1; m_pa = m_p;
      end
      if (!m_ab && (m_p == W + 2) && (m_fcnt != 255)) m_fcnt++;
      m_p++;
      if (m_p == (m_ab ? m_pa + G + 1 : W + 2 + G)) m_busy = 1'b0;
    end
  end

  // Captured output stream, oldest bit in the higher position
  logic [7:0] cap   = '0;
  int         cap_n = 0;

  // Per-cycle compare of every output against the frame timeline
  always @(posedge CLK) begin
    int   last_act, last_bv, j;
    logic e_enb, e_bv, e_bit, e_done;
    logic [1:0] e_modo;
    #1;
    last_act = m_ab ? m_pa : W + 1;
    last_bv  = m_ab ? m_pa : W + 2;
    e_enb    = m_busy && (m_p <= last_act);
    e_modo   = !e_enb ? 2'b00 : ((m_p == 1) ? 2'b10 : 2'b01);
    e_bv     = m_busy && (m_p >= 3) && (m_p <= last_bv);
    j        = m_p - 3;
    e_bit    = 1'b0;
    if (e_bv) e_bit = m_dir ? m_word[W-1-j] : m_word[j];
    e_done   = m_busy && !m_ab && (m_p == W + 2);
    chk("cyc_ready", 32'(CMD_READY), 32'(!m_busy));
    chk("cyc_enb",   32'(SR_ENB),    32'(e_enb));
    chk("cyc_modo",  32'(SR_MODO),   32'(e_modo));
    chk("cyc_dir",   32'(SR_DIR),    32'(m_dir));
    chk("cyc_d",     32'(SR_D),      32'(m_word));
    chk("cyc_sin",   32'(SR_S_IN),   32'd0);
    chk("cyc_bv",    32'(BIT_VALID), 32'(e_bv));
    chk("cyc_bit",   32'(BIT_OUT),   32'(e_bit));
    chk("cyc_done",  32'(DONE),      32'(e_done));
    chk("cyc_fcnt",  32'(FRAME_CNT), 32'(m_fcnt));
    if (BIT_VALID === 1'b1) begin
      cap = {cap[6:0], BIT_OUT};
      cap_n++;
    end
  end

  // Wait (bounded) at negedges until the sequencer is ready
  task automatic wait_ready();
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Offer one word; returns at the negedge inside cycle 1 with the inputs scrambled
  task automatic send(input logic [W-1:0] d, input logic dr);
    wait_ready();
    CMD_VALID = 1'b1; CMD_DATA = d; CMD_DIR = dr;
    @(negedge CLK);
    CMD_VALID = 1'b0; CMD_DATA = ~d; CMD_DIR = ~dr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_L = 1'b0; CMD_VALID = 1'b0; CMD_DATA = '0; CMD_DIR = 1'b0; ABORT = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_modo",  32'(SR_MODO),   32'd0);
    chk("rst_fcnt",  32'(FRAME_CNT), 32'd0);
    RESET_L = 1'b1;
    @(negedge CLK);

    // MSB-first 1011
    cap = '0; cap_n = 0;
    send(4'b1011, 1'b1);
    chk("msb_c1_modo", 32'(SR_MODO), 32'h2);
    chk("msb_c1_enb",  32'(SR_ENB),  32'd1);
    @(negedge CLK);
    chk("msb_c2_modo", 32'(SR_MODO), 32'h1);
    chk("msb_c2_dir",  32'(SR_DIR),  32'd1);
    repeat (4) @(negedge CLK);
    chk("msb_c6_done", 32'(DONE), 32'd1);
    @(negedge CLK);
    chk("msb_c7_ready", 32'(CMD_READY), 32'd1);
    chk("msb_bits",     32'(cap[3:0]),  32'hB);
    chk("msb_fcnt",     32'(FRAME_CNT), 32'd1);

    // LSB-first 1011
    cap = '0; cap_n = 0;
    send(4'b1011, 1'b0);
    repeat (2) @(negedge CLK);
    chk("lsb_c3_dir", 32'(SR_DIR), 32'd0);
    repeat (4) @(negedge CLK);
    chk("lsb_bits", 32'(cap[3:0]),  32'hD);
    chk("lsb_fcnt", 32'(FRAME_CNT), 32'd2);

    // Back-to-back with CMD_VALID held: A then 5
    cap = '0; cap_n = 0;
    wait_ready();
    CMD_VALID = 1'b1; CMD_DATA = 4'hA; CMD_DIR = 1'b1;
    @(negedge CLK);
    CMD_DATA = 4'h5;
    repeat (5) @(negedge CLK);
    chk("b2b_c6_busy", 32'(CMD_READY), 32'd0);
    @(negedge CLK);
    chk("b2b_c7_ready", 32'(CMD_READY), 32'd1);
    @(negedge CLK);
    chk("b2b_f2_load", 32'(SR_MODO), 32'h2);
    CMD_VALID = 1'b0; CMD_DATA = 4'h0;
    repeat (6) @(negedge CLK);
    chk("b2b_bits", 32'(cap),       32'hA5);
    chk("b2b_fcnt", 32'(FRAME_CNT), 32'd4);

    // Abort during the first shift
    cap = '0; cap_n = 0;
    send(4'b0110, 1'b1);
    repeat (2) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abt_c4_bv", 32'(BIT_VALID), 32'd0);
    @(negedge CLK);
    chk("abt_c5_ready", 32'(CMD_READY), 32'd1);
    chk("abt_bits_n",   32'(cap_n),     32'd1);
    chk("abt_fcnt",     32'(FRAME_CNT), 32'd4);

    // ABORT coinciding with an accepting edge: command still taken
    ABORT = 1'b1;
    send(4'b1001, 1'b0);
    ABORT = 1'b0;
    chk("abt_acc_load", 32'(SR_MODO), 32'h2);
    repeat (6) @(negedge CLK);
    chk("abt_acc_fcnt", 32'(FRAME_CNT), 32'd5);

    // Saturation: continuous traffic well past 255 frames
    CMD_VALID = 1'b1;
    repeat (256 * 7) begin
      @(negedge CLK);
      CMD_DATA = W'($urandom);
      CMD_DIR  = 1'($urandom);
    end
    chk("sat_255", 32'(FRAME_CNT), 32'd255);
    repeat (8) @(negedge CLK);
    chk("sat_hold", 32'(FRAME_CNT), 32'd255);
    CMD_VALID = 1'b0;

    // Reset in cycle 3 of a frame
    send(4'hF, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RESET_L = 1'b0; CMD_VALID = 1'b1; CMD_DATA = 4'h3; CMD_DIR = 1'b1;
    #1;
    chk("mrst_ready", 32'(CMD_READY), 32'd1);
    chk("mrst_enb",   32'(SR_ENB),    32'd0);
    chk("mrst_modo",  32'(SR_MODO),   32'd0);
    chk("mrst_dir",   32'(SR_DIR),    32'd0);
    chk("mrst_d",     32'(SR_D),      32'd0);
    chk("mrst_sin",   32'(SR_S_IN),   32'd0);
    chk("mrst_bv",    32'(BIT_VALID), 32'd0);
    chk("mrst_bit",   32'(BIT_OUT),   32'd0);
    chk("mrst_done",  32'(DONE),      32'd0);
    chk("mrst_fcnt",  32'(FRAME_CNT), 32'd0);
    repeat (2) @(negedge CLK);
    chk("mrst_noacc", 32'(SR_MODO), 32'd0);
    RESET_L = 1'b1;
    @(negedge CLK);
    chk("mrst_first_load", 32'(SR_MODO), 32'h2);
    chk("mrst_first_d",    32'(SR_D),    32'h3);
    CMD_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    chk("mrst_fcnt_after", 32'(FRAME_CNT), 32'd1);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_reg_ctrl
`default_nettype wire
